ps2_dir_decoder: RTL

PS2_DIR_DECODER -- requirements
Module: ps2_dir_decoder

---
 rtl/ps2_dir_decoder_if.sv | 33 +++
 rtl/ps2_dir_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_dir_decoder_if.sv
// PS/2 keyboard direction decoder: shared types and port bundle.
// Keyboard lines in, decoded direction and scan-code events out.
package ps2_dir_pkg;
   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;
endpackage

interface ps2_dir_if;
   import ps2_dir_pkg::*;
   logic       ps2_clk;
   logic       ps2_data;
   logic       dir_change;
   dir_t       dir;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_error;

   modport master (
      input  ps2_clk, ps2_data,
      output dir_change, dir, scan_code,
      output scan_valid, frame_error
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  dir_change, dir, scan_code,
      input  scan_valid, frame_error
   );
endinterface

// File: rtl/ps2_dir_decoder.sv
// PS/2 receiver with clock glitch filter, frame checking and a
// scan-code decoder that turns arrow / WASD make codes into directions.
module ps2_dir_decoder
   import ps2_dir_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic     clock,
   input  logic     reset,
   ps2_dir_if.master io
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_PAR  = 2'd2;
   localparam logic [1:0] S_STOP = 2'd3;

   logic           clk_s1, clk_s2, dat_s1, dat_s2;
   logic           filt, fall;
   logic [FCW-1:0] fcnt;
   logic [1:0]     state;
   logic [2:0]     bit_cnt;
   logic [7:0]     shift;
   logic           par;
   logic [TCW-1:0] tmo;
   logic [7:0]     scan_q;
   logic           sv_q, fe_q, dc_q;
   logic           ext, brk;
   dir_t           dir_q, map_dir;
   logic           hit;

   always_ff @(posedge clock) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
         filt   <= 1'b1;
         fcnt   <= '0;
         fall   <= 1'b0;
      end else begin
         clk_s1 <= io.ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= io.ps2_data;
         dat_s2 <= dat_s1;
         fall   <= 1'b0;
         if (clk_s2 != filt) begin
            if (fcnt == F_LAST) begin
               filt <= clk_s2;
               fcnt <= '0;
               fall <= filt;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end else begin
            fcnt <= '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         par     <= 1'b0;
         tmo     <= '0;
         scan_q  <= 8'h00;
         sv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         sv_q <= 1'b0;
         fe_q <= 1'b0;
         if (state == S_IDLE || fall) tmo <= '0;
         else                         tmo <= tmo + 1'b1;
         if (fall) begin
            unique case (state)
               S_IDLE: begin
                  bit_cnt <= '0;
                  if (dat_s2) fe_q  <= 1'b1;
                  else        state <= S_DATA;
               end
               S_DATA: begin
                  shift   <= {dat_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= S_PAR;
               end
               S_PAR: begin
                  par   <= dat_s2;
                  state <= S_STOP;
               end
               S_STOP: begin
                  // Odd parity: data plus parity bit must hold an odd count of ones
                  if (dat_s2 && ^{shift, par}) begin
                     scan_q <= shift;
                     sv_q   <= 1'b1;
                  end else begin
                     fe_q <= 1'b1;
                  end
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end else if (state != S_IDLE && tmo == T_LAST) begin
            fe_q  <= 1'b1;
            state <= S_IDLE;
         end
      end
   end

   always_comb begin
      hit     = 1'b1;
      map_dir = dir_q;
      unique case (1'b1)
         (ext && scan_q == 8'h75), (!ext && scan_q == 8'h1D): map_dir = UP;
         (ext && scan_q == 8'h72), (!ext && scan_q == 8'h1B): map_dir = DOWN;
         (ext && scan_q == 8'h6B), (!ext && scan_q == 8'h1C): map_dir = LEFT;
         (ext && scan_q == 8'h74), (!ext && scan_q == 8'h23): map_dir = RIGHT;
         default: hit = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ext   <= 1'b0;
         brk   <= 1'b0;
         dir_q <= RIGHT;
         dc_q  <= 1'b0;
      end else begin
         dc_q <= 1'b0;
         if (fe_q) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (sv_q) begin
            if (scan_q == 8'hE0) begin
               ext <= 1'b1;
            end else if (scan_q == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (!brk && hit) begin
                  dir_q <= map_dir;
                  dc_q  <= 1'b1;
               end
            end
         end
      end
   end

   assign io.dir_change  = dc_q;
   assign io.dir         = dir_q;
   assign io.scan_code   = scan_q;
   assign io.scan_valid  = sv_q;
   assign io.frame_error = fe_q;

endmodule
